csa_resolver: RTL

//  Converts a carry-save (redundant) operand pair, as produced by the CSA stages,

---
 rtl/csa_resolver.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/csa_resolver.sv
// csa_resolver: resolves a carry-save pair (sum, carry) into a binary value,
// CHUNK bits per clock, through a ripple of full-adder cells. The carry
// between chunks is held in a register. Handshakes use valid/ready on both
// sides. While an operand pair is in flight, no other input is accepted.

// One full-adder cell of the per-chunk ripple.
module csa_fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module csa_resolver #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic             out_cout
);

  // Number of chunks, and the width of the chunk counter.
  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] sum_reg;        // captured sum, shifted right as chunks are consumed
  logic [WIDTH-1:0] carry_reg;      // captured carry, shifted in step with sum_reg
  logic [WIDTH-1:0] value_reg;      // result, filled from the top one chunk at a time
  logic [IDXW-1:0]  idx_reg;        // index of the chunk handled on the next BUSY edge
  logic             run_carry_reg;  // carry into the current chunk
  logic             cout_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;

  // The current chunk always sits in the low CHUNK bits of the working registers.
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_s;
  logic [CHUNK:0]   rip;
  logic             chunk_cout;

  assign chunk_a    = sum_reg[CHUNK-1:0];
  assign chunk_b    = carry_reg[CHUNK-1:0];
  assign rip[0]     = run_carry_reg;
  assign chunk_cout = rip[CHUNK];

  // Ripple of full adders across one chunk.
  generate
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_cell
      csa_fulladder u_fa (
        .a    (chunk_a[gi]),
        .b    (chunk_b[gi]),
        .cin  (rip[gi]),
        .s    (chunk_s[gi]),
        .cout (rip[gi+1])
      );
    end
  endgenerate

  // Next values of the shifting registers. The operands move down by one chunk.
  // The result enters from the top, so after N steps it is aligned.
  logic [WIDTH-1:0] sum_shift;
  logic [WIDTH-1:0] carry_shift;
  logic [WIDTH-1:0] value_shift;

  generate
    if (CHUNK == WIDTH) begin : g_single
      assign sum_shift   = '0;
      assign carry_shift = '0;
      assign value_shift = chunk_s;
    end else begin : g_multi
      assign sum_shift   = {{CHUNK{1'b0}}, sum_reg[WIDTH-1:CHUNK]};
      assign carry_shift = {{CHUNK{1'b0}}, carry_reg[WIDTH-1:CHUNK]};
      assign value_shift = {chunk_s, value_reg[WIDTH-1:CHUNK]};
    end
  endgenerate

  // Control FSM and datapath registers. Reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      sum_reg       <= '0;
      carry_reg     <= '0;
      value_reg     <= '0;
      idx_reg       <= '0;
      run_carry_reg <= 1'b0;
      cout_reg      <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            sum_reg       <= in_sum;
            carry_reg     <= in_carry;
            idx_reg       <= '0;
            run_carry_reg <= 1'b0;
            in_ready_reg  <= 1'b0;
            state_reg     <= BUSY;
          end
        end
        BUSY: begin
          sum_reg       <= sum_shift;
          carry_reg     <= carry_shift;
          value_reg     <= value_shift;
          run_carry_reg <= chunk_cout;
          if (idx_reg == LAST_IDX) begin
            cout_reg      <= chunk_cout;
            idx_reg       <= '0;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_value = value_reg;
  assign out_cout  = cout_reg;

endmodule
